// File: rtl/iterative_divider_pkg.sv
// rtl/iterative_divider_pkg.sv - shared types and operation decode for the iterative divider
//
// Purpose: divide/remainder operation encoding, divider FSM states and a
// decode helper used by the top module.
// Ports: none (package).

`ifndef XLEN
`ifdef XLEN_64
`define XLEN 64
`else
`define XLEN 32
`endif
`endif

package iterative_divider_pkg;

  // The W members only exist on a 64-bit datapath; on a 32-bit core their
  // encodings are decoded as illegal.
  typedef enum logic [2:0] {
    DIV   = 3'd0,
    DIVU  = 3'd1,
    REM   = 3'd2,
    REMU  = 3'd3
`ifdef XLEN_64
    ,
    DIVW  = 3'd4,
    DIVUW = 3'd5,
    REMW  = 3'd6,
    REMUW = 3'd7
`endif
  } div_operation_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  typedef struct packed {
    logic legal;
    logic is_rem;
    logic is_signed;
    logic is_w;
  } op_decode_t;

  function automatic op_decode_t decode_op(input logic [2:0] op);
    op_decode_t d;
    d = '{legal: 1'b0, is_rem: 1'b0, is_signed: 1'b0, is_w: 1'b0};
    case (op)
      3'd0: d = '{legal: 1'b1, is_rem: 1'b0, is_signed: 1'b1, is_w: 1'b0};
      3'd1: d = '{legal: 1'b1, is_rem: 1'b0, is_signed: 1'b0, is_w: 1'b0};
      3'd2: d = '{legal: 1'b1, is_rem: 1'b1, is_signed: 1'b1, is_w: 1'b0};
      3'd3: d = '{legal: 1'b1, is_rem: 1'b1, is_signed: 1'b0, is_w: 1'b0};
`ifdef XLEN_64
      3'd4: d = '{legal: 1'b1, is_rem: 1'b0, is_signed: 1'b1, is_w: 1'b1};
      3'd5: d = '{legal: 1'b1, is_rem: 1'b0, is_signed: 1'b0, is_w: 1'b1};
      3'd6: d = '{legal: 1'b1, is_rem: 1'b1, is_signed: 1'b1, is_w: 1'b1};
      3'd7: d = '{legal: 1'b1, is_rem: 1'b1, is_signed: 1'b0, is_w: 1'b1};
`endif
      default: d = '{legal: 1'b0, is_rem: 1'b0, is_signed: 1'b0, is_w: 1'b0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/divider_step.sv
// rtl/divider_step.sv - one combinational radix-2 restoring division step
//
// Purpose: shift remainder:quotient left by one, trial-subtract the divisor
// and keep the difference when it is non-negative.
// Ports:
//   rem_i  partial remainder (always < div_i)
//   quo_i  quotient / remaining dividend bits
//   div_i  divisor magnitude
//   rem_o  next partial remainder
//   quo_o  next quotient, new bit in position 0

module divider_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  // One extra bit: the shifted remainder can reach 2*div_i-1, and the top
  // bit of the difference acts as the borrow (negative trial result).
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    shifted = {rem_i, quo_i[XLEN-1]};
    diff    = shifted - {1'b0, div_i};
    quo_o   = {quo_i[XLEN-2:0], ~diff[XLEN]};
    rem_o   = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
  end

endmodule

// File: rtl/iterative_divider.sv
// rtl/iterative_divider.sv - multi-cycle restoring divide/remainder unit
//
// Purpose: DIV/DIVU/REM/REMU (plus W variants on 64-bit) with valid/ready
// handshakes on both operand and result sides.
// Ports:
//   clk           rising-edge clock
//   reset         synchronous active-low reset
//   Flush         squash the in-flight operation from any state
//   InValid       operands/operation valid
//   InReady       unit can accept (IDLE only)
//   DivOperation  operation select
//   DividendA     dividend
//   DivisorB      divisor
//   OutValid      DivResult/DivByZero valid
//   OutReady      consumer accepts the result
//   DivResult     quotient or remainder
//   DivByZero     divisor was zero (qualified by OutValid)

module iterative_divider
  import iterative_divider_pkg::*;
#(
  parameter int XLEN      = `XLEN,
  parameter int WORD_SIZE = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Flush,
  input  logic            InValid,
  output logic            InReady,
  input  div_operation_e  DivOperation,
  input  logic [XLEN-1:0] DividendA,
  input  logic [XLEN-1:0] DivisorB,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [XLEN-1:0] DivResult,
  output logic            DivByZero
);

  localparam int CNT_W  = $clog2(XLEN);
  localparam int WSHIFT = (XLEN > WORD_SIZE) ? (XLEN - WORD_SIZE) : 0;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(WORD_SIZE - 1);
  localparam logic [XLEN-1:0]  XLEN_MIN = {1'b1, {(XLEN-1){1'b0}}};

  // Shift-based extension so the same code works when XLEN == WORD_SIZE.
  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] x);
    return XLEN'($signed(x << WSHIFT) >>> WSHIFT);
  endfunction

  function automatic logic [XLEN-1:0] zext_w(input logic [XLEN-1:0] x);
    return (x << WSHIFT) >> WSHIFT;
  endfunction

  div_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            is_rem_q, is_rem_d;
  logic            is_w_q, is_w_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            dbz_q, dbz_d;
  logic            out_valid_q, out_valid_d;

  // Accept-time operand preparation.
  op_decode_t      dec;
  logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs;
  logic            a_neg, b_neg;
  logic            b_zero, overflow;
  logic [XLEN-1:0] min_val;
  logic [XLEN-1:0] quo_init;
  logic [XLEN-1:0] rem_dz;

  always_comb begin
    dec = decode_op(DivOperation);
    if (dec.is_w) begin
      a_ext   = dec.is_signed ? sext_w(DividendA) : zext_w(DividendA);
      b_ext   = dec.is_signed ? sext_w(DivisorB)  : zext_w(DivisorB);
      min_val = sext_w(XLEN'(1) << (WORD_SIZE - 1));
    end else begin
      a_ext   = DividendA;
      b_ext   = DivisorB;
      min_val = XLEN_MIN;
    end
    a_neg    = dec.is_signed & a_ext[XLEN-1];
    b_neg    = dec.is_signed & b_ext[XLEN-1];
    a_abs    = a_neg ? -a_ext : a_ext;
    b_abs    = b_neg ? -b_ext : b_ext;
    b_zero   = (b_ext == '0);
    overflow = dec.is_signed & (a_ext == min_val) & (b_ext == '1);
    // W dividends start at the top so WORD_SIZE shifts consume every bit.
    quo_init = dec.is_w ? (a_abs << WSHIFT) : a_abs;
    rem_dz   = dec.is_w ? sext_w(DividendA) : DividendA;
  end

  logic [XLEN-1:0] step_rem, step_quo;

  divider_step #(
    .XLEN (XLEN)
  ) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // Sign fixup applied to the final step's outputs.
  logic [XLEN-1:0] fix_quo, fix_rem, fix_sel, fix_res;

  always_comb begin
    fix_quo = neg_quo_q ? -step_quo : step_quo;
    fix_rem = neg_rem_q ? -step_rem : step_rem;
    fix_sel = is_rem_q ? fix_rem : fix_quo;
    fix_res = is_w_q ? sext_w(fix_sel) : fix_sel;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    is_rem_d    = is_rem_q;
    is_w_d      = is_w_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    result_d    = result_q;
    dbz_d       = dbz_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (InValid) begin
          is_rem_d  = dec.is_rem;
          is_w_d    = dec.is_w;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          if (!dec.legal) begin
            state_d     = ST_DONE;
            result_d    = 'x;
            dbz_d       = 1'b0;
            out_valid_d = 1'b1;
          end else if (b_zero) begin
            state_d     = ST_DONE;
            result_d    = dec.is_rem ? rem_dz : '1;
            dbz_d       = 1'b1;
            out_valid_d = 1'b1;
          end else if (overflow) begin
            state_d     = ST_DONE;
            result_d    = dec.is_rem ? '0 : a_ext;
            dbz_d       = 1'b0;
            out_valid_d = 1'b1;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = dec.is_w ? CNT_WORD : CNT_FULL;
            rem_d   = '0;
            quo_d   = quo_init;
            dvs_d   = b_abs;
          end
        end
      end
      ST_BUSY: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == '0) begin
          state_d     = ST_DONE;
          result_d    = fix_res;
          dbz_d       = 1'b0;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (OutReady) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    // Squash wins over both accept and the result handshake.
    if (Flush) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      is_rem_q    <= 1'b0;
      is_w_q      <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      result_q    <= '0;
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      is_rem_q    <= is_rem_d;
      is_w_q      <= is_w_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      result_q    <= result_d;
      dbz_q       <= dbz_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign InReady   = (state_q == ST_IDLE);
  assign OutValid  = out_valid_q;
  assign DivResult = result_q;
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_iterative_divider.sv
// tb/tb_iterative_divider.sv - self-checking bench for iterative_divider

module tb_iterative_divider;
  import iterative_divider_pkg::*;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           flush = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  div_operation_e op = DIV;
  logic [31:0]    a = '0;
  logic [31:0]    b = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [31:0]    res;
  logic           dbz;

  iterative_divider #(.XLEN(32), .WORD_SIZE(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .Flush        (flush),
    .InValid      (in_valid),
    .InReady      (in_ready),
    .DivOperation (op),
    .DividendA    (a),
    .DivisorB     (b),
    .OutValid     (out_valid),
    .OutReady     (out_ready),
    .DivResult    (res),
    .DivByZero    (dbz)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] res;
    bit          dbz;
    int          acc;
    int          lat;
    bit          seen;
  } exp_t;

  exp_t q[$];
  int   hold_cnt = 0;
  bit   check_idle_next = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic plus the two special cases.
  function automatic void model(input div_operation_e o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output bit z, output int lat);
    int sx, sy;
    sx  = x;
    sy  = y;
    z   = (y == 0);
    lat = 33;
    r   = '0;
    case (o)
      DIV: begin
        if (y == 0) begin r = 32'hFFFF_FFFF; lat = 1; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin r = x; lat = 1; end
        else r = sx / sy;
      end
      DIVU: begin
        if (y == 0) begin r = 32'hFFFF_FFFF; lat = 1; end
        else r = x / y;
      end
      REM: begin
        if (y == 0) begin r = x; lat = 1; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin r = 0; lat = 1; end
        else r = sx % sy;
      end
      default: begin
        if (y == 0) begin r = x; lat = 1; end
        else r = x % y;
      end
    endcase
  endfunction

  // Compare process: every cycle with OutValid the outputs must match the
  // oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) continue;
      if (check_idle_next) begin
        check_idle_next = 1'b0;
        chk("inready_after_pop", 32'(in_ready), 32'd1);
        chk("outvalid_after_pop", 32'(out_valid), 32'd0);
      end
      if (hold_cnt > 0) out_ready = 1'b0;
      else out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_outvalid", 32'(out_valid), 32'd0);
        end else begin
          if (!q[0].seen) begin
            q[0].seen = 1'b1;
            chk("latency", 32'(cyc - q[0].acc + 1), 32'(q[0].lat));
          end
          chk("result", res, q[0].res);
          chk("div_by_zero", 32'(dbz), 32'(q[0].dbz));
          chk("inready_in_done", 32'(in_ready), 32'd0);
          if (hold_cnt > 0) hold_cnt--;
          else if (out_ready) begin
            void'(q.pop_front());
            check_idle_next = 1'b1;
          end
        end
      end else if (q.size() > 0 && (cyc - q[0].acc) > 80) begin
        checks++;
        errors++;
        $display("FAIL result_timeout: no OutValid, expected %h", q[0].res);
        void'(q.pop_front());
      end
    end
  end

  task automatic issue(input div_operation_e o, input logic [31:0] x, input logic [31:0] y,
                       input bit expect_result);
    int guard;
    logic [31:0] r;
    bit z;
    int l;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 300) begin
      a = $urandom;
      b = $urandom;
      op = div_operation_e'(3'($urandom_range(0, 3)));
      @(negedge clk);
      guard++;
    end
    chk("inready_before_accept", 32'(in_ready), 32'd1);
    if (!in_ready) return;
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    if (expect_result) begin
      model(o, x, y, r, z, l);
      q.push_back('{res: r, dbz: z, acc: cyc, lat: l, seen: 1'b0});
    end
    in_valid = 1'b0;
    op = div_operation_e'(3'($urandom_range(0, 3)));
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    @(negedge clk);
    while ((q.size() != 0 || !in_ready) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] mr;
    bit mz;
    int ml;
    div_operation_e ro;
    logic [31:0] ra, rb;
    int sel;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_inready", 32'(in_ready), 32'd1);
    chk("reset_outvalid", 32'(out_valid), 32'd0);
    chk("reset_result", res, 32'd0);
    chk("reset_dbz", 32'(dbz), 32'd0);
    reset = 1'b1;

    // Pin the model with hand-computed values.
    model(DIV, 32'hFFFF_FFF9, 32'd2, mr, mz, ml);
    chk("model_div_neg", mr, 32'hFFFF_FFFD);
    chk("model_div_lat", 32'(ml), 32'd33);
    model(REM, 32'hFFFF_FFF9, 32'd2, mr, mz, ml);
    chk("model_rem_neg", mr, 32'hFFFF_FFFF);
    model(DIVU, 32'd100, 32'd7, mr, mz, ml);
    chk("model_divu", mr, 32'd14);
    model(REMU, 32'd100, 32'd7, mr, mz, ml);
    chk("model_remu", mr, 32'd2);
    model(DIVU, 32'd5, 32'd0, mr, mz, ml);
    chk("model_dz", mr, 32'hFFFF_FFFF);
    chk("model_dz_flag", 32'(mz), 32'd1);
    chk("model_dz_lat", 32'(ml), 32'd1);
    model(DIV, 32'h8000_0000, 32'hFFFF_FFFF, mr, mz, ml);
    chk("model_ovf", mr, 32'h8000_0000);
    chk("model_ovf_lat", 32'(ml), 32'd1);

    // Directed cases through the DUT.
    issue(DIV,  32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(REM,  32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(DIVU, 32'd100, 32'd7, 1'b1);
    issue(REMU, 32'd100, 32'd7, 1'b1);
    issue(DIVU, 32'hFFFF_FFFF, 32'd1, 1'b1);
    issue(DIVU, 32'd5, 32'd0, 1'b1);
    issue(REM,  32'd5, 32'd0, 1'b1);
    issue(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(REM,  32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

    // Backpressure for 10 cycles, then a back-to-back accept.
    wait_drain();
    hold_cnt = 10;
    issue(DIVU, 32'd1000, 32'd9, 1'b1);
    issue(REM, 32'hFFFF_FF00, 32'd7, 1'b1);

    // Randomised operations with corner-biased operands.
    for (int i = 0; i < 150; i++) begin
      ro = div_operation_e'(3'($urandom_range(0, 3)));
      sel = $urandom_range(0, 7);
      ra = (sel == 0) ? 32'h8000_0000 : (sel == 1) ? 32'($urandom_range(0, 1000)) : 32'($urandom);
      sel = $urandom_range(0, 7);
      rb = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFF_FFFF :
           (sel == 2) ? 32'($urandom_range(1, 20)) : (sel == 3) ? (32'($urandom) >> $urandom_range(0, 31)) :
           32'($urandom);
      issue(ro, ra, rb, 1'b1);
    end

    // Flush on the 10th BUSY cycle.
    wait_drain();
    issue(DIV, 32'd1000, 32'd3, 1'b0);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_inready", 32'(in_ready), 32'd1);
    chk("flush_outvalid", 32'(out_valid), 32'd0);
    repeat (40) @(negedge clk);

    // Leave a nonzero result registered, then reset mid-operation.
    issue(DIVU, 32'd100, 32'd7, 1'b1);
    wait_drain();
    issue(DIV, 32'd1000, 32'd3, 1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_inready", 32'(in_ready), 32'd1);
    chk("midreset_outvalid", 32'(out_valid), 32'd0);
    chk("midreset_result", res, 32'd0);
    chk("midreset_dbz", 32'(dbz), 32'd0);
    reset = 1'b1;
    repeat (40) @(negedge clk);

    // InValid with Flush on the same edge: nothing is accepted.
    in_valid = 1'b1;
    op = DIVU;
    a = 32'd10;
    b = 32'd2;
    flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b0;
    chk("flush_accept_inready", 32'(in_ready), 32'd1);
    chk("flush_accept_outvalid", 32'(out_valid), 32'd0);
    repeat (40) @(negedge clk);

    issue(DIV, 32'hFFFF_FF9C, 32'd7, 1'b1);
    wait_drain();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
